// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start bit, DATA_BITS data bits LSB first,
// optional parity, 1 or 2 stop bits, with a baud divider and a one-cycle done strobe.
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 TX_EN,
  input  logic [DATA_BITS-1:0] TX_DATA,
  output logic                 TX_STATUS,
  output logic                 UART_TX,
  output logic                 TX_DONE
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
  localparam bit               HAS_PARITY = (PARITY != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  // Odd parity makes the total count of ones (data + parity) odd.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    if (PARITY == 1) begin
      return ~^d;
    end else begin
      return ^d;
    end
  endfunction

  state_e               state_q;
  logic [CNT_W-1:0]     div_q;
  logic [BIT_W-1:0]     bit_cnt_q;
  logic                 stop_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 parity_q;
  logic                 tx_q;
  logic                 status_q;
  logic                 done_q;

  logic div_last_s;
  logic accept_s;

  // Divider terminal count and frame-accept qualifier.
  always_comb begin
    div_last_s = (div_q == DIV_LAST);
    accept_s   = TX_EN & status_q;
  end

  // Frame FSM with registered line, status and done outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      div_q      <= {CNT_W{1'b0}};
      bit_cnt_q  <= {BIT_W{1'b0}};
      stop_cnt_q <= 1'b0;
      shift_q    <= {DATA_BITS{1'b0}};
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
      status_q   <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != S_IDLE) begin
        div_q <= div_last_s ? {CNT_W{1'b0}} : div_q + CNT_W'(1);
      end else begin
        div_q <= {CNT_W{1'b0}};
      end
      case (state_q)
        S_IDLE: begin
          if (accept_s) begin
            shift_q    <= TX_DATA;
            parity_q   <= parity_of(TX_DATA);
            bit_cnt_q  <= {BIT_W{1'b0}};
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b0;
            status_q   <= 1'b0;
            state_q    <= S_START;
          end
        end
        S_START: begin
          if (div_last_s) begin
            tx_q      <= shift_q[0];
            shift_q   <= shift_q >> 1;
            bit_cnt_q <= {BIT_W{1'b0}};
            state_q   <= S_DATA;
          end
        end
        S_DATA: begin
          if (div_last_s) begin
            if (bit_cnt_q == BIT_LAST) begin
              if (HAS_PARITY) begin
                tx_q    <= parity_q;
                state_q <= S_PARITY;
              end else begin
                tx_q       <= 1'b1;
                stop_cnt_q <= 1'b0;
                state_q    <= S_STOP;
              end
            end else begin
              tx_q      <= shift_q[0];
              shift_q   <= shift_q >> 1;
              bit_cnt_q <= bit_cnt_q + BIT_W'(1);
            end
          end
        end
        S_PARITY: begin
          if (div_last_s) begin
            tx_q       <= 1'b1;
            stop_cnt_q <= 1'b0;
            state_q    <= S_STOP;
          end
        end
        S_STOP: begin
          if (div_last_s) begin
            if (stop_cnt_q == STOP_LAST) begin
              status_q <= 1'b1;
              done_q   <= 1'b1;
              state_q  <= S_IDLE;
            end else begin
              stop_cnt_q <= stop_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          tx_q     <= 1'b1;
          status_q <= 1'b1;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

  assign UART_TX   = tx_q;
  assign TX_STATUS = status_q;
  assign TX_DONE   = done_q;

endmodule
